// File: rtl/wb_pkg.sv
// Shared definitions for the register-file write port: default widths,
// the buffered entry layout, write-source encoding and a register-range helper.
package wb_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 4;
    localparam int NUM_REGS = 15;

    // One retired result waiting for the write port.
    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } wb_entry_t;

    // Which source drives the write port on a given edge.
    typedef enum logic [1:0] {
        SRC_IDLE = 2'd0,
        SRC_DBG  = 2'd1,
        SRC_FIFO = 2'd2,
        SRC_IN   = 2'd3
    } wb_src_e;

    // True when idx names an implemented register.
    function automatic logic is_valid_reg(input int unsigned idx, input int unsigned num_regs);
        return idx < num_regs;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// Small synchronous FIFO holding retired results. The head is read
// combinationally so the arbiter can forward it on the same edge it pops.
module wb_fifo #(
    parameter int WIDTH = 36,
    parameter int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic             pop_i,
    input  logic [WIDTH-1:0] din_i,
    output logic [WIDTH-1:0] head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             push_ok;
    logic             pop_ok;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_ptr_q];

    // A pop frees a slot on the same edge, so push into a full FIFO is legal when popping.
    assign pop_ok  = pop_i && !empty_o;
    assign push_ok = push_i && (!full_o || pop_ok);

    // Storage: each slot captures the incoming word when the write pointer selects it.
    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_slot
            // Slot write; storage itself needs no reset.
            always_ff @(posedge clk) begin
                if (push_ok && (wr_ptr_q == PTR_W'(gi))) begin
                    mem_q[gi] <= din_i;
                end
            end
        end
    endgenerate

    // Next pointers wrap modulo DEPTH; occupancy tracks push minus pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) begin
            wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
        end
        if (pop_ok) begin
            rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
        end
        case ({push_ok, pop_ok})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    // Pointer and occupancy registers; reset empties the FIFO.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

endmodule

// File: rtl/wb_write_port.sv
// Register-file write port. Accepts retiring instructions over valid/ready,
// buffers them, and arbitrates the single write port against a debug channel
// with a bounded debug burst. Writes to unimplemented registers are dropped.
// Optional performance counters are built when WB_PERF_CNT_EN is defined.
module wb_write_port #(
    parameter int DATA_W        = wb_pkg::DATA_W,
    parameter int ADDR_W        = wb_pkg::ADDR_W,
    parameter int NUM_REGS      = wb_pkg::NUM_REGS,
    parameter int BUF_DEPTH     = 2,
    parameter int DBG_MAX_BURST = 2
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             in_valid,
    output logic                             in_ready,
    input  logic                             wbEn_in,
    input  logic                             memR_en_in,
    input  logic [ADDR_W-1:0]                Dest_in,
    input  logic [DATA_W-1:0]                ALU_result_in,
    input  logic [DATA_W-1:0]                Mem_read_value_in,
    input  logic                             dbg_req,
    input  logic [ADDR_W-1:0]                dbg_dest,
    input  logic [DATA_W-1:0]                dbg_data,
    output logic                             dbg_ack,
    output logic                             writeBackEn,
    output logic [ADDR_W-1:0]                Dest_wb,
    output logic [DATA_W-1:0]                Result_wb,
    output logic [$clog2(BUF_DEPTH+1)-1:0]   buf_count
`ifdef WB_PERF_CNT_EN
    ,
    output logic [31:0]                      perf_writes,
    output logic [31:0]                      perf_stall
`endif
);

    import wb_pkg::*;

    localparam int CNT_W   = $clog2(BUF_DEPTH + 1);
    localparam int BURST_W = (DBG_MAX_BURST > 0) ? $clog2(DBG_MAX_BURST + 1) : 1;
    localparam int ENTRY_W = ADDR_W + DATA_W;

    typedef struct packed {
        logic [ADDR_W-1:0] dest;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t             in_entry;
    entry_t             head_entry;
    logic [ENTRY_W-1:0] head_raw;
    logic               fifo_push;
    logic               fifo_pop;
    logic               fifo_full;
    logic               fifo_empty;
    logic [CNT_W-1:0]   fifo_count;

    logic               accept;
    logic               in_keep;
    logic               dbg_dest_ok;
    logic               dbg_blocked;
    wb_src_e            src_sel;

    logic [BURST_W-1:0] burst_q, burst_d;
    logic               wb_en_q, wb_en_d;
    logic [ADDR_W-1:0]  dest_q, dest_d;
    logic [DATA_W-1:0]  result_q, result_d;
    logic               dbg_ack_q, dbg_ack_d;

    // Ready depends only on the registered occupancy (and reset), never on this cycle's requests.
    assign in_ready = !rst && !fifo_full;
    assign accept   = in_valid && in_ready;

    // Only entries that will actually write an implemented register take a slot.
    assign in_keep     = accept && wbEn_in && is_valid_reg(32'(Dest_in), NUM_REGS);
    assign dbg_dest_ok = is_valid_reg(32'(dbg_dest), NUM_REGS);

    assign in_entry.dest = Dest_in;
    assign in_entry.data = memR_en_in ? Mem_read_value_in : ALU_result_in;

    // Debug yields to buffered work once it has taken DBG_MAX_BURST grants in a row.
    assign dbg_blocked = (burst_q == BURST_W'(DBG_MAX_BURST)) && !fifo_empty;

    wb_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .din_i   (in_entry),
        .head_o  (head_raw),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign head_entry = head_raw;

    // Source arbitration: debug, then FIFO head, then flow-through of the new entry.
    always_comb begin
        src_sel = SRC_IDLE;
        if (dbg_req && dbg_dest_ok && !dbg_blocked) begin
            src_sel = SRC_DBG;
        end else if (!fifo_empty) begin
            src_sel = SRC_FIFO;
        end else if (in_keep) begin
            src_sel = SRC_IN;
        end
    end

    // Next write-port contents, FIFO control, debug ack and burst tracking.
    always_comb begin
        wb_en_d   = 1'b0;
        dest_d    = dest_q;
        result_d  = result_q;
        fifo_pop  = 1'b0;
        fifo_push = in_keep && (src_sel != SRC_IN);
        // Out-of-range debug targets are acked without a write so the requester is released.
        dbg_ack_d = dbg_req && (!dbg_dest_ok || (src_sel == SRC_DBG));
        burst_d   = burst_q;

        case (src_sel)
            SRC_DBG: begin
                wb_en_d  = 1'b1;
                dest_d   = dbg_dest;
                result_d = dbg_data;
            end
            SRC_FIFO: begin
                wb_en_d  = 1'b1;
                dest_d   = head_entry.dest;
                result_d = head_entry.data;
                fifo_pop = 1'b1;
            end
            SRC_IN: begin
                wb_en_d  = 1'b1;
                dest_d   = in_entry.dest;
                result_d = in_entry.data;
            end
            default: begin
                wb_en_d = 1'b0;
            end
        endcase

        if (fifo_empty) begin
            burst_d = '0;
        end else if (src_sel == SRC_DBG) begin
            burst_d = burst_q + 1'b1;
        end else if (src_sel == SRC_FIFO) begin
            burst_d = '0;
        end
    end

    // Write-port output registers and burst counter.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wb_en_q   <= 1'b0;
            dest_q    <= '0;
            result_q  <= '0;
            dbg_ack_q <= 1'b0;
            burst_q   <= '0;
        end else begin
            wb_en_q   <= wb_en_d;
            dest_q    <= dest_d;
            result_q  <= result_d;
            dbg_ack_q <= dbg_ack_d;
            burst_q   <= burst_d;
        end
    end

    assign writeBackEn = wb_en_q;
    assign Dest_wb     = dest_q;
    assign Result_wb   = result_q;
    assign dbg_ack     = dbg_ack_q;
    assign buf_count   = fifo_count;

`ifdef WB_PERF_CNT_EN
    logic [31:0] perf_writes_q;
    logic [31:0] perf_stall_q;

    // Free-running event counters; they wrap naturally at 2^32.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_writes_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (wb_en_q) begin
                perf_writes_q <= perf_writes_q + 32'd1;
            end
            if (in_valid && !in_ready) begin
                perf_stall_q <= perf_stall_q + 32'd1;
            end
        end
    end

    assign perf_writes = perf_writes_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_wb_write_port.sv
// Self-checking bench for wb_write_port: directed stimulus pushes expected
// writes into a scoreboard queue; a negedge monitor pops and compares every
// write the DUT presents.
`timescale 1ns/1ps
module tb_wb_write_port;
    import wb_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        wbEn_in;
    logic        memR_en_in;
    logic [3:0]  Dest_in;
    logic [31:0] ALU_result_in;
    logic [31:0] Mem_read_value_in;
    logic        dbg_req;
    logic [3:0]  dbg_dest;
    logic [31:0] dbg_data;
    logic        dbg_ack;
    logic        writeBackEn;
    logic [3:0]  Dest_wb;
    logic [31:0] Result_wb;
    logic [1:0]  buf_count;
`ifdef WB_PERF_CNT_EN
    logic [31:0] perf_writes;
    logic [31:0] perf_stall;
`endif

    int vectors     = 0;
    int miscompares = 0;
    int ack_cnt     = 0;
    wb_entry_t exp_q[$];

    always #5 clk = ~clk;

    wb_write_port dut (
        .clk               (clk),
        .rst               (rst),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .wbEn_in           (wbEn_in),
        .memR_en_in        (memR_en_in),
        .Dest_in           (Dest_in),
        .ALU_result_in     (ALU_result_in),
        .Mem_read_value_in (Mem_read_value_in),
        .dbg_req           (dbg_req),
        .dbg_dest          (dbg_dest),
        .dbg_data          (dbg_data),
        .dbg_ack           (dbg_ack),
        .writeBackEn       (writeBackEn),
        .Dest_wb           (Dest_wb),
        .Result_wb         (Result_wb),
        .buf_count         (buf_count)
`ifdef WB_PERF_CNT_EN
        ,
        .perf_writes       (perf_writes),
        .perf_stall        (perf_stall)
`endif
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, required %0h", name, act, exp);
        end
    endtask

    function automatic wb_entry_t ent(input logic [3:0] d, input logic [31:0] v);
        wb_entry_t e;
        e.dest = d;
        e.data = v;
        return e;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        in_valid          = 1'b0;
        wbEn_in           = 1'b0;
        memR_en_in        = 1'b0;
        Dest_in           = '0;
        ALU_result_in     = '0;
        Mem_read_value_in = '0;
        dbg_req           = 1'b0;
        dbg_dest          = '0;
        dbg_data          = '0;
    endtask

    task automatic set_in(input logic [3:0] d, input logic [31:0] alu, input logic [31:0] mem,
                          input logic memr, input logic wben);
        in_valid          = 1'b1;
        Dest_in           = d;
        ALU_result_in     = alu;
        Mem_read_value_in = mem;
        memR_en_in        = memr;
        wbEn_in           = wben;
    endtask

    task automatic set_dbg(input logic [3:0] d, input logic [31:0] v);
        dbg_req  = 1'b1;
        dbg_dest = d;
        dbg_data = v;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_wben"},  writeBackEn, 0);
        check({tag, "_dest"},  Dest_wb,     0);
        check({tag, "_data"},  Result_wb,   0);
        check({tag, "_ack"},   dbg_ack,     0);
        check({tag, "_count"}, buf_count,   0);
        check({tag, "_ready"}, in_ready,    0);
    endtask

    // Scoreboard monitor: every presented write must match the head of the expected queue.
    always @(negedge clk) begin
        wb_entry_t e;
        if (!rst) begin
            if (dbg_ack) ack_cnt++;
            if (writeBackEn) begin
                if (exp_q.size() == 0) begin
                    vectors++;
                    miscompares++;
                    $display("FAIL unexpected_write: got dest=%0d data=%h, required no write", Dest_wb, Result_wb);
                end else begin
                    e = exp_q.pop_front();
                    $display("write dest=%0d data=%h (expected dest=%0d data=%h)", Dest_wb, Result_wb, e.dest, e.data);
                    check("wb_dest", Dest_wb, e.dest);
                    check("wb_data", Result_wb, e.data);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int ack0;
        int idx;
        logic rdy;
        logic exp_rdy [8];
        wb_entry_t bp_ent [4];

        // ---------------- Reset state ----------------
        rst = 1'b1;
        idle_inputs();
        #2;
        check_reset_outputs("rst0");
        tick();
        rst = 1'b0;
        @(negedge clk);
        check("rst0_ready_after", in_ready, 1);
        tick();

        // ---------------- Flow-through: load then ALU ----------------
        set_in(4'd3, 32'd5, 32'hDEAD_BEEF, 1'b1, 1'b1);
        exp_q.push_back(ent(4'd3, 32'hDEAD_BEEF));
        tick();
        set_in(4'd7, 32'h1234_5678, 32'hFFFF_0000, 1'b0, 1'b1);
        exp_q.push_back(ent(4'd7, 32'h1234_5678));
        tick();
        idle_inputs();
        tick();
        check("flow_count", buf_count, 0);

        // ---------------- Drops: Dest 15 and wbEn_in=0 ----------------
        set_in(4'd15, 32'h0BAD_0001, 32'h0, 1'b0, 1'b1);
        @(negedge clk);
        check("drop15_ready", in_ready, 1);
        tick();
        set_in(4'd4, 32'h0BAD_0002, 32'h0, 1'b0, 1'b0);
        tick();
        idle_inputs();
        @(negedge clk);
        check("drop_count", buf_count, 0);
        check("drop_wben", writeBackEn, 0);
        check("idle_hold_dest", Dest_wb, 7);
        check("idle_hold_data", Result_wb, 32'h1234_5678);
        tick();

        // ---------------- Debug to nonexistent register ----------------
        ack0 = ack_cnt;
        set_dbg(4'd15, 32'hFACE_0000);
        tick();
        idle_inputs();
        @(negedge clk);
        check("dbg15_ack", dbg_ack, 1);
        check("dbg15_wben", writeBackEn, 0);
        tick();
        check("dbg15_ack_count", ack_cnt - ack0, 1);

        // ---------------- Debug contention with two buffered entries ----------------
        ack0 = ack_cnt;
        exp_q.push_back(ent(4'd14, 32'hD000_0000));
        exp_q.push_back(ent(4'd14, 32'hD000_0001));
        exp_q.push_back(ent(4'd14, 32'hD000_0002));
        exp_q.push_back(ent(4'd1,  32'h0000_0011));
        exp_q.push_back(ent(4'd14, 32'hD000_0004));
        exp_q.push_back(ent(4'd2,  32'h0000_0022));
        set_in(4'd1, 32'h11, 32'h0, 1'b0, 1'b1);
        set_dbg(4'd14, 32'hD000_0000);
        tick();
        set_in(4'd2, 32'h22, 32'h0, 1'b0, 1'b1);
        set_dbg(4'd14, 32'hD000_0001);
        tick();
        in_valid = 1'b0;
        set_dbg(4'd14, 32'hD000_0002);
        @(negedge clk);
        check("cont_count_full", buf_count, 2);
        check("cont_ready_full", in_ready, 0);
        tick();
        set_dbg(4'd14, 32'hD000_0003);
        tick();
        set_dbg(4'd14, 32'hD000_0004);
        tick();
        idle_inputs();
        tick();
        tick();
        check("cont_ack_count", ack_cnt - ack0, 4);
        check("cont_drained", exp_q.size(), 0);

        // ---------------- Reset mid-burst with two entries buffered ----------------
        exp_q.push_back(ent(4'd14, 32'hAAAA_0001));
        set_in(4'd5, 32'h55, 32'h0, 1'b0, 1'b1);
        set_dbg(4'd14, 32'hAAAA_0001);
        tick();
        set_in(4'd6, 32'h66, 32'h0, 1'b0, 1'b1);
        set_dbg(4'd14, 32'hAAAA_0002);
        tick();
        #1;
        rst = 1'b1;
        #1;
        check_reset_outputs("rst1");
        idle_inputs();
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst1_ready_after", in_ready, 1);
        check("rst1_count_after", buf_count, 0);
        repeat (4) tick();
        check("rst1_no_stale", writeBackEn, 0);
        check("rst1_queue", exp_q.size(), 0);

        // ---------------- Backpressure: debug holds the port, 4 entries streamed ----------------
        ack0 = ack_cnt;
        exp_rdy = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        bp_ent[0] = ent(4'd1, 32'hB0);
        bp_ent[1] = ent(4'd2, 32'hB1);
        bp_ent[2] = ent(4'd3, 32'hB2);
        bp_ent[3] = ent(4'd4, 32'hB3);
        exp_q.push_back(ent(4'd13, 32'hCC));
        exp_q.push_back(ent(4'd13, 32'hCC));
        exp_q.push_back(ent(4'd13, 32'hCC));
        exp_q.push_back(bp_ent[0]);
        exp_q.push_back(ent(4'd13, 32'hCC));
        exp_q.push_back(ent(4'd13, 32'hCC));
        exp_q.push_back(bp_ent[1]);
        exp_q.push_back(ent(4'd13, 32'hCC));
        exp_q.push_back(bp_ent[2]);
        exp_q.push_back(bp_ent[3]);
        idx = 0;
        for (int c = 0; c < 8; c++) begin
            set_dbg(4'd13, 32'hCC);
            if (idx < 4) set_in(bp_ent[idx].dest, bp_ent[idx].data, 32'h0, 1'b0, 1'b1);
            else in_valid = 1'b0;
            @(negedge clk);
            check($sformatf("bp_ready_c%0d", c), in_ready, exp_rdy[c]);
            rdy = in_ready;
            @(posedge clk);
            if (in_valid && rdy) idx++;
            #1;
        end
        idle_inputs();
        check("bp_accepted", idx, 4);
        repeat (4) tick();
        check("bp_ack_count", ack_cnt - ack0, 6);
        check("bp_drained", exp_q.size(), 0);

`ifdef WB_PERF_CNT_EN
        // ---------------- Performance counters ----------------
        rst = 1'b1;
        tick();
        rst = 1'b0;
        exp_q.push_back(ent(4'd12, 32'hE1));
        exp_q.push_back(ent(4'd12, 32'hE2));
        exp_q.push_back(ent(4'd12, 32'hE3));
        exp_q.push_back(ent(4'd1,  32'h71));
        exp_q.push_back(ent(4'd2,  32'h72));
        set_in(4'd1, 32'h71, 32'h0, 1'b0, 1'b1);
        set_dbg(4'd12, 32'hE1);
        tick();
        set_in(4'd2, 32'h72, 32'h0, 1'b0, 1'b1);
        set_dbg(4'd12, 32'hE2);
        tick();
        set_in(4'd3, 32'h73, 32'h0, 1'b0, 1'b1);
        set_dbg(4'd12, 32'hE3);
        tick();
        tick();
        idle_inputs();
        repeat (3) tick();
        check("perf_writes", perf_writes, 5);
        check("perf_stall", perf_stall, 2);
        check("perf_drained", exp_q.size(), 0);
`endif

        check("final_queue_empty", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
